// File: rtl/dcsa64_pkg.sv
// Shared types and helpers for the dcsa64_ctrl sequencer.
// Holds the operand width, the controller state encoding, the
// operand parity helper and the packed response record.
package dcsa64_pkg;

    localparam int WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        CHECK = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef struct packed {
        logic             id;
        logic [WIDTH-1:0] sum;
        logic             err;
    } rsp_t;

    // Even parity (XOR reduction) of a 64-bit operand.
    function automatic logic parity64(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/dcsa64_rr_arb.sv
// Two-way round-robin arbiter. The pointer names the requester that wins
// under contention; after a grant the pointer moves to the other one.
module dcsa64_rr_arb (
    input  logic [1:0] valid_i,
    input  logic       ptr_i,
    input  logic       en_i,
    output logic [1:0] grant_o,
    output logic       ptr_nxt_o
);

    // Pointer requester first, otherwise the other one if it is valid.
    always_comb begin
        grant_o   = 2'b00;
        ptr_nxt_o = ptr_i;
        if (valid_i[ptr_i]) begin
            grant_o[ptr_i] = 1'b1;
        end else if (valid_i[~ptr_i]) begin
            grant_o[~ptr_i] = 1'b1;
        end
        if (en_i && (|grant_o)) begin
            ptr_nxt_o = ~grant_o[1];
        end
    end

endmodule

// File: rtl/duplicated_carry_select_adder_64.sv
// Dual-rail 64-bit carry-select adder with a parity echo.
// s is the true-rail sum, s_invert the inverted sum taken from a second,
// duplicate adder, papb echoes the input parities, pab is the parity of the sum.
module duplicated_carry_select_adder_64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        pa,
    input  logic        pb,
    output logic [63:0] s,
    output logic [63:0] s_invert,
    output logic        papb,
    output logic        pab
);

    // Four 16-bit blocks, each precomputing carry-in 0 and 1 results.
    function automatic logic [63:0] csel_add(input logic [63:0] x, input logic [63:0] y);
        logic [63:0] r;
        logic [16:0] s0;
        logic [16:0] s1;
        logic        c;
        r = '0;
        c = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s0 = {1'b0, x[k*16 +: 16]} + {1'b0, y[k*16 +: 16]};
            s1 = s0 + 17'd1;
            r[k*16 +: 16] = c ? s1[15:0] : s0[15:0];
            c = c ? s1[16] : s0[16];
        end
        return r;
    endfunction

    logic [63:0] sum_true;
    logic [63:0] sum_dup;

    assign sum_true = csel_add(a, b);
    assign sum_dup  = csel_add(a, b);
    assign s        = sum_true;
    assign s_invert = ~sum_dup;
    assign papb     = pa ^ pb;
    assign pab      = ^sum_true;

endmodule

// File: rtl/dcsa64_ctrl.sv
// Sequencer/arbiter around one duplicated_carry_select_adder_64.
// Two requesters share the adder round-robin; each op is evaluated from
// registered operands, checked (true vs inverted rail, parity echo) and
// returned over a valid/ready response port with an error flag.
// Optional build macro DCSA_RETRY_EN: a first check failure re-evaluates
// the same operands once before reporting an error.
module dcsa64_ctrl #(
    parameter int WIDTH     = 64,
    parameter int ERR_CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [1:0][WIDTH-1:0]      req_a,
    input  logic [1:0][WIDTH-1:0]      req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_id,
    output logic [WIDTH-1:0]           rsp_sum,
    output logic                       rsp_err,
    output logic [ERR_CNT_W-1:0]       err_cnt,
    output logic                       busy
);

    import dcsa64_pkg::*;

    // Fault counter increment that sticks at all-ones.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
        return (&c) ? c : c + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    endfunction

    state_e               state_q;
    logic                 rr_ptr_q;
    logic                 rr_ptr_d;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic                 id_q;
    logic                 pa_q;
    logic                 pb_q;
    logic [WIDTH-1:0]     s_q;
    logic [WIDTH-1:0]     s_inv_q;
    logic                 papb_q;
    logic                 dbg_pab_unused_q;
`ifdef DCSA_RETRY_EN
    logic                 retry_q;
`endif
    rsp_t                 rsp_q;
    logic                 rsp_valid_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    logic [1:0]           grant;
    logic                 gnt_id;
    logic                 hs;
    logic                 check_ok;
    logic [WIDTH-1:0]     s_w;
    logic [WIDTH-1:0]     s_inv_w;
    logic                 papb_w;
    logic                 pab_w;

    dcsa64_rr_arb u_arb (
        .valid_i   (req_valid),
        .ptr_i     (rr_ptr_q),
        .en_i      (hs),
        .grant_o   (grant),
        .ptr_nxt_o (rr_ptr_d)
    );

    duplicated_carry_select_adder_64 u_adder (
        .a        (a_q),
        .b        (b_q),
        .pa       (pa_q),
        .pb       (pb_q),
        .s        (s_w),
        .s_invert (s_inv_w),
        .papb     (papb_w),
        .pab      (pab_w)
    );

    // Accept only in IDLE and never while reset is asserted.
    assign req_ready = ((state_q == IDLE) && rst_n) ? grant : 2'b00;
    assign hs        = |(req_ready & req_valid);
    assign gnt_id    = grant[1];
    assign check_ok  = (s_q == ~s_inv_q) && (papb_q == (pa_q ^ pb_q));

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_q.id;
    assign rsp_sum   = rsp_q.sum;
    assign rsp_err   = rsp_q.err;
    assign err_cnt   = err_cnt_q;
    assign busy      = (state_q != IDLE);

    // Round-robin pointer advances only on an accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Controller FSM: latch operands, evaluate, check, then respond.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            a_q              <= '0;
            b_q              <= '0;
            id_q             <= 1'b0;
            pa_q             <= 1'b0;
            pb_q             <= 1'b0;
            s_q              <= '0;
            s_inv_q          <= '0;
            papb_q           <= 1'b0;
            dbg_pab_unused_q <= 1'b0;
`ifdef DCSA_RETRY_EN
            retry_q          <= 1'b0;
`endif
            rsp_q            <= '0;
            rsp_valid_q      <= 1'b0;
            err_cnt_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hs) begin
                        a_q     <= req_a[gnt_id];
                        b_q     <= req_b[gnt_id];
                        id_q    <= gnt_id;
                        pa_q    <= parity64(req_a[gnt_id]);
                        pb_q    <= parity64(req_b[gnt_id]);
                        state_q <= EVAL;
                    end
                end
                EVAL: begin
                    s_q              <= s_w;
                    s_inv_q          <= s_inv_w;
                    papb_q           <= papb_w;
                    dbg_pab_unused_q <= pab_w;
                    state_q          <= CHECK;
                end
                CHECK: begin
                    if (check_ok) begin
                        rsp_q       <= '{id: id_q, sum: s_q, err: 1'b0};
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        err_cnt_q <= sat_inc(err_cnt_q);
`ifdef DCSA_RETRY_EN
                        if (!retry_q) begin
                            retry_q <= 1'b1;
                            state_q <= EVAL;
                        end else begin
                            rsp_q       <= '{id: id_q, sum: s_q, err: 1'b1};
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end
`else
                        rsp_q       <= '{id: id_q, sum: s_q, err: 1'b1};
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
`endif
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
`ifdef DCSA_RETRY_EN
                        retry_q     <= 1'b0;
`endif
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dcsa64_ctrl.md
Name: dcsa64_ctrl

Overview:
- Sequencer and arbiter wrapping one duplicated_carry_select_adder_64 instance, a dual-rail 64-bit adder with a parity echo.
- Shares the adder between two requesters using round-robin arbitration.
- Generates operand parities, registers adder outputs and checks them: true rail against inverted rail, and parity echo.
- Returns a sum plus error flag over a valid/ready response port and keeps a saturating fault counter for the safety monitor.

Parameters:
WIDTH, 64, operand/sum width; must match the adder (fixed 64).
ERR_CNT_W, 8, width of saturating fault counter.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  2  per-requester request valid.
req_ready  out  2  per-requester accept; one-hot or zero.
req_a  in  2xWIDTH  operand A per requester.
req_b  in  2xWIDTH  operand B per requester.
rsp_valid  out  1  response valid.
rsp_ready  in  1  response accept.
rsp_id  out  1  index of the requester being answered.
rsp_sum  out  WIDTH  sum mod 2^WIDTH (true rail).
rsp_err  out  1  uncorrected check failure for this op.
err_cnt  out  ERR_CNT_W  saturating count of failed checks.
busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE, rr_ptr=0.
  - All operand/result registers 0, retry flag 0.
  - Outputs: req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_err=0, err_cnt=0, busy=0.
- States: IDLE, EVAL, CHECK, RESP.
- IDLE:
  - Grant = rr_ptr requester if its valid is set, else the other requester if valid.
  - req_ready is combinationally 1 only for the granted requester, and only in IDLE.
  - On handshake: latch a, b and id; compute pa = ^a and pb = ^b; rr_ptr <= ~grant; go to EVAL.
  - If both requesters are valid, rr_ptr wins, so sustained contention alternates 0,1,0,1.
- EVAL:
  - Adder inputs come from registers only; the adder is combinational.
  - Sample s, s_invert, papb and pab into registers; go to CHECK.
- CHECK:
  - ok = (s_r == ~s_inv_r) && (papb_r == pa_r ^ pb_r).
  - ok: go to RESP with rsp_err=0.
  - Not ok: err_cnt increments, saturating at all-ones; behaviour then follows the optional feature.
- RESP:
  - rsp_valid=1; rsp_sum, rsp_id and rsp_err are held stable until rsp_ready.
  - On the handshake cycle: go to IDLE, clear the retry flag and drop rsp_valid next cycle.
  - No new request is accepted before returning to IDLE (one op in flight).
- Latency: request handshake at cycle N gives rsp_valid=1 at cycle N+3 (no retry). Maximum throughput is one op per 4 cycles with rsp_ready held high.
- pab is registered and exposed for debug only; it does not take part in the check.
- Requester valid dropping while not granted is legal. Payload must stay stable while valid is high and not yet accepted.
- Reset asserted mid-operation: immediate return to reset state; the in-flight op is discarded with no response.

Optional Feature:
- Macro: DCSA_RETRY_EN.
- Defined:
  - On the first CHECK failure of an op, set the retry flag and return to EVAL, re-evaluating the same registered operands. Latency becomes N+5.
  - A second failure goes to RESP with rsp_err=1.
  - err_cnt counts every failure, including the one that was retried.
- Undefined: any failure goes directly to RESP with rsp_err=1; the retry flag logic is absent.

Decomposition:
- Package dcsa64_pkg:
  - WIDTH localparam.
  - state_e enum {IDLE, EVAL, CHECK, RESP}.
  - Function parity64().
  - Response struct {id, sum, err}.
- One natural sub-module: dcsa64_rr_arb, a 2-way round-robin arbiter (valid[1:0], ptr, handshake enable -> grant one-hot, next ptr).
- Adder instantiated unchanged inside dcsa64_ctrl.

Test Plan:
- Reset, then req0 with a=64'h0000_0000_0000_0001, b=64'hFFFF_FFFF_FFFF_FFFF -> rsp_sum=0, rsp_id=0, rsp_err=0, rsp_valid exactly 3 cycles after handshake.
- Both requesters valid continuously with rsp_ready=1, 6 ops -> grant order 0,1,0,1,0,1; every sum matches a+b mod 2^64; one op per 4 cycles.
- rsp_ready held low 5 cycles -> rsp_valid and payload stable; req_ready stays 0 throughout; a new request is accepted only after the handshake.
- Force s_invert bit 7 flipped once (bind/force) with DCSA_RETRY_EN defined -> retry, rsp_err=0, err_cnt=1, latency 5. With the macro undefined -> rsp_err=1, err_cnt=1.
- Force papb mismatch permanently over 300 ops -> every rsp_err=1; err_cnt saturates at 8'hFF and does not wrap.
- Assert rst_n low during EVAL -> all outputs 0 immediately; after release, no stale response; the next op is correct.
